// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter for the single write port of a register
// bank. It drives the per-register write enables and a shared data bus, and it
// provides a scrub sequence that writes zero into every register in turn.
// All outputs are registered.
module reg_write_arbiter #(
  parameter int N      = 8,
  parameter int NREQ   = 3,
  parameter int ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ*N-1:0]        data,
  input  logic                     scrub_start,
  output logic [NREQ-1:0]          gnt,
  output logic [(1<<ADDR_W)-1:0]   wr_en,
  output logic [N-1:0]             wr_data,
  output logic                     busy,
  output logic                     scrub_done
);

  localparam int          R      = 1 << ADDR_W;
  localparam int          PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NREQ_U = NREQ;

  typedef enum logic {
    IDLE,
    SCRUB
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  // Scrub index counts 1..R; reaching R marks the completion cycle.
  logic [ADDR_W:0]     idx_q, idx_d;

  logic [NREQ-1:0]     gnt_d;
  logic [R-1:0]        wr_en_d;
  logic [N-1:0]        wr_data_d;
  logic                busy_d;
  logic                done_d;

  logic                found;
  logic [PTR_W-1:0]    win;
  logic [ADDR_W-1:0]   win_addr;
  logic [N-1:0]        win_data;

  // Round-robin search: first set request at or after ptr, wrapping around.
  always_comb begin
    int unsigned cand;
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int unsigned j = 0; j < NREQ_U; j++) begin
      cand = 32'(ptr_q) + j;
      if (cand >= NREQ_U) begin
        cand = cand - NREQ_U;
      end
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand[PTR_W-1:0];
      end
    end
    win_addr = addr[win*ADDR_W +: ADDR_W];
    win_data = data[win*N +: N];
  end

  // Next-state and next-output logic for the IDLE/SCRUB controller.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    gnt_d     = '0;
    wr_en_d   = '0;
    wr_data_d = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (scrub_start) begin
          // First scrub write is issued on the entry edge itself.
          state_d    = SCRUB;
          wr_en_d[0] = 1'b1;
          busy_d     = 1'b1;
          idx_d      = (ADDR_W+1)'(1);
        end else if (found) begin
          gnt_d[win]        = 1'b1;
          wr_en_d[win_addr] = 1'b1;
          wr_data_d         = win_data;
          if (win == PTR_W'(NREQ - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = win + 1'b1;
          end
        end
      end
      SCRUB: begin
        if (idx_q == (ADDR_W+1)'(R)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          idx_d   = '0;
        end else begin
          wr_en_d[idx_q[ADDR_W-1:0]] = 1'b1;
          busy_d                     = 1'b1;
          idx_d                      = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer, index and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      idx_q      <= '0;
      gnt        <= '0;
      wr_en      <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      scrub_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      gnt        <= gnt_d;
      wr_en      <= wr_en_d;
      wr_data    <= wr_data_d;
      busy       <= busy_d;
      scrub_done <= done_d;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: a transaction-level model predicts
// every output cycle, and directed literal checks pin the model and the bank.
module tb_reg_write_arbiter;

  localparam int N      = 8;
  localparam int NREQ   = 3;
  localparam int ADDR_W = 3;
  localparam int R      = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        scrub_start;
  logic [2:0]  req;
  logic [8:0]  addr;
  logic [23:0] data;
  logic [2:0]  gnt;
  logic [7:0]  wr_en;
  logic [7:0]  wr_data;
  logic        busy;
  logic        scrub_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_write_arbiter #(.N(N), .NREQ(NREQ), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .addr        (addr),
    .data        (data),
    .scrub_start (scrub_start),
    .gnt         (gnt),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .busy        (busy),
    .scrub_done  (scrub_done)
  );

  // Register bank fed by the arbiter outputs (not reset, like the real bank).
  logic [7:0] bank [R];
  always @(posedge clk) begin
    for (int k = 0; k < R; k++) begin
      if (wr_en[k] === 1'b1) bank[k] <= wr_data;
    end
  end

  // Model: a scrub is a queue of pre-built output beats; otherwise round-robin.
  typedef struct packed {
    logic [2:0] g;
    logic [7:0] we;
    logic [7:0] wd;
    logic       busy;
    logic       done;
  } beat_t;

  beat_t exp_b;
  beat_t pend[$];
  int    ptr_m = 0;
  bit    armed = 1'b0;

  always @(posedge clk) begin
    beat_t b;
    beat_t w;
    int    winner;
    b      = '0;
    winner = -1;
    if (rst) begin
      pend.delete();
      ptr_m = 0;
    end else if (pend.size() != 0) begin
      b = pend.pop_front();
    end else if (scrub_start) begin
      for (int k = 0; k < R; k++) begin
        w      = '0;
        w.we   = 8'b1 << k;
        w.busy = 1'b1;
        pend.push_back(w);
      end
      w      = '0;
      w.done = 1'b1;
      pend.push_back(w);
      b = pend.pop_front();
    end else begin
      for (int j = 0; j < NREQ; j++) begin
        int i;
        i = (ptr_m + j) % NREQ;
        if (winner < 0 && req[i]) winner = i;
      end
      if (winner >= 0) begin
        b.g   = 3'b1 << winner;
        b.we  = 8'b1 << addr[winner*3 +: 3];
        b.wd  = data[winner*8 +: 8];
        ptr_m = (winner + 1) % NREQ;
      end
    end
    exp_b = b;
    armed = 1'b1;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (armed) begin
      checks++;
      if ({gnt, wr_en, wr_data, busy, scrub_done} !== exp_b) begin
        failures++;
        $display("FAIL model_cmp t=%0t got gnt=%b wr_en=%h wr_data=%h busy=%b done=%b required gnt=%b wr_en=%h wr_data=%h busy=%b done=%b",
                 $time, gnt, wr_en, wr_data, busy, scrub_done,
                 exp_b.g, exp_b.we, exp_b.wd, exp_b.busy, exp_b.done);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [2:0] a, input logic [7:0] d);
    addr[i*3 +: 3] = a;
    data[i*8 +: 8] = d;
  endtask

  logic [2:0] rr_exp [6];
  logic [2:0] alt_exp [4];

  initial begin
    rr_exp  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    alt_exp = '{3'b001, 3'b100, 3'b001, 3'b100};
    rst         = 1'b1;
    scrub_start = 1'b0;
    req         = 3'b111;
    addr        = '0;
    data        = '0;
    set_src(0, 3'd1, 8'h10);
    set_src(1, 3'd2, 8'h20);
    set_src(2, 3'd3, 8'h30);

    // Reset with all requests high.
    cyc();
    chk("rst_outputs_0", 32'({gnt, wr_en, wr_data, busy, scrub_done}), 32'd0);
    cyc();
    chk("rst_outputs_1", 32'({gnt, wr_en, wr_data, busy, scrub_done}), 32'd0);
    rst = 1'b0;
    cyc();
    chk("first_gnt", 32'(gnt), 32'b001);
    chk("first_wr_en", 32'(wr_en), 32'h02);
    req = 3'b000;
    cyc();

    // Single write from requester 1.
    req = 3'b010;
    set_src(1, 3'd5, 8'h55);
    cyc();
    chk("single_gnt", 32'(gnt), 32'b010);
    chk("single_wr_en", 32'(wr_en), 32'h20);
    chk("single_wr_data", 32'(wr_data), 32'h55);
    req = 3'b000;
    cyc();
    chk("single_bank5", 32'(bank[5]), 32'h55);

    // Round-robin from a fresh pointer.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("rr_all", 32'(gnt), 32'(rr_exp[k]));
    end
    req = 3'b101;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("rr_drop1", 32'(gnt), 32'(alt_exp[k]));
    end
    req = 3'b000;
    cyc();

    // Same-address collision with ptr back at 0.
    set_src(0, 3'd3, 8'hAA);
    set_src(2, 3'd3, 8'h11);
    req = 3'b101;
    cyc();
    chk("coll_gnt0", 32'(gnt), 32'b001);
    chk("coll_data0", 32'(wr_data), 32'hAA);
    req = 3'b100;
    cyc();
    chk("coll_gnt2", 32'(gnt), 32'b100);
    chk("coll_data2", 32'(wr_data), 32'h11);
    req = 3'b000;
    cyc();
    chk("coll_bank3", 32'(bank[3]), 32'h11);

    // Scrub with requester 1 pending.
    for (int k = 0; k < R; k++) begin
      req = 3'b001;
      set_src(0, 3'(k), 8'hFF);
      cyc();
    end
    req = 3'b000;
    cyc();
    scrub_start = 1'b1;
    req = 3'b010;
    set_src(1, 3'd6, 8'h5A);
    cyc();
    scrub_start = 1'b0;
    chk("scrub_wr_en0", 32'(wr_en), 32'h01);
    chk("scrub_busy0", 32'(busy), 32'd1);
    for (int k = 1; k < R; k++) begin
      cyc();
      chk("scrub_wr_en", 32'(wr_en), 32'(8'h01 << k));
      chk("scrub_busy_gnt", 32'({busy, gnt}), 32'b1000);
    end
    cyc();
    chk("scrub_done", 32'({scrub_done, busy, wr_en}), 32'h200);
    cyc();
    chk("post_scrub_gnt", 32'(gnt), 32'b010);
    chk("post_scrub_wr_en", 32'(wr_en), 32'h40);
    chk("post_scrub_data", 32'(wr_data), 32'h5A);
    req = 3'b000;
    cyc();
    for (int k = 0; k < R; k++) begin
      chk("scrub_bank", 32'(bank[k]), (k == 6) ? 32'h5A : 32'h00);
    end

    // Reset arriving where the k=4 scrub write would have been issued.
    for (int k = 0; k < R; k++) begin
      req = 3'b001;
      set_src(0, 3'(k), 8'hFF);
      cyc();
    end
    req = 3'b000;
    cyc();
    scrub_start = 1'b1;
    cyc();
    scrub_start = 1'b0;
    for (int k = 1; k < 4; k++) begin
      cyc();
      chk("abort_wr_en", 32'(wr_en), 32'(8'h01 << k));
    end
    rst = 1'b1;
    cyc();
    chk("abort_rst_out", 32'({gnt, wr_en, wr_data, busy, scrub_done}), 32'd0);
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      chk("abort_no_done", 32'({scrub_done, busy}), 32'd0);
    end
    for (int k = 0; k < R; k++) begin
      chk("abort_bank", 32'(bank[k]), (k >= 4) ? 32'hFF : 32'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
